// File: rtl/max_stream_extract_if.sv
// Bundle of the vector input stream, the light_core side-channel
// and the sorted output stream of max_stream_extract.
interface max_stream_extract_if #(
    parameter int M = 4,
    parameter int N = 4
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic                the_unused_guard;
    logic                i_valid;
    logic                o_ready;
    logic [M-1:0][N-1:0] i_data;
    logic [M-1:0][N-1:0] o_core_chi;
    logic [M-1:0]        i_core_h0;
    logic                o_valid;
    logic                i_ready;
    logic [N-1:0]        o_data;
    logic [IW-1:0]       o_index;
    logic                o_last;

    assign the_unused_guard = 1'b0;

    modport master (
        output i_valid, i_data, i_core_h0, i_ready,
        input  o_ready, o_core_chi, o_valid, o_data, o_index, o_last
    );

    modport slave (
        input  i_valid, i_data, i_core_h0, i_ready,
        output o_ready, o_core_chi, o_valid, o_data, o_index, o_last
    );
endinterface

// File: rtl/max_stream_extract.sv
// Streams a captured vector out in descending order using the
// max-mask returned by an external light_core.
package sort_pkg;
    localparam int M = 4;
    localparam int N = 4;
endpackage

module max_stream_extract
    import sort_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    max_stream_extract_if.slave  bus
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int RW = $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, SEL, EMIT} state_t;

    state_t              state_q;
    logic [M-1:0][N-1:0] work_q;
    logic [M-1:0]        alive_q;
    logic [RW-1:0]       remain_q;
    logic                ready_q;
    logic                valid_q;
    logic [N-1:0]        data_q;
    logic [IW-1:0]       index_q;
    logic                last_q;

    logic [M-1:0]        cand;
    logic [IW-1:0]       pick;

    always_comb begin
        for (int q = 0; q < M; q++) begin
            bus.o_core_chi[q] = alive_q[q] ? work_q[q] : '0;
        end
    end

    assign cand = bus.i_core_h0 & alive_q;

    // Lowest candidate wins so equal words leave in index order.
    always_comb begin
        pick = '0;
        for (int q = M - 1; q >= 0; q--) begin
            if (cand[q]) pick = IW'(q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            alive_q  <= '0;
            remain_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        work_q   <= bus.i_data;
                        alive_q  <= '1;
                        remain_q <= RW'(M);
                        ready_q  <= 1'b0;
                        state_q  <= SEL;
                    end
                end
                SEL: begin
                    data_q  <= work_q[pick];
                    index_q <= pick;
                    last_q  <= (remain_q == RW'(1));
                    valid_q <= 1'b1;
                    state_q <= EMIT;
                end
                EMIT: begin
                    if (bus.i_ready) begin
                        alive_q[index_q] <= 1'b0;
                        remain_q         <= remain_q - RW'(1);
                        valid_q          <= 1'b0;
                        if (last_q) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            state_q <= SEL;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_index = index_q;
    assign bus.o_last  = last_q;

    // An empty candidate set means the core disagrees with alive_q.
    a_cand_nonempty: assert property (
        @(posedge i_clk) disable iff (i_rst)
        (state_q == SEL) |-> (cand != '0)
    ) else $fatal(1, "FAIL cand_empty in SEL");
endmodule
